// File: rtl/sqrt_pkg.sv
// ============================================================================
// Module   : sqrt_pkg
// Purpose  : Shared state encoding and width helpers for square_root_seq.
// Revision : 1.0
// ============================================================================
`default_nettype none

package sqrt_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    function automatic int result_len(input int word_length, input int frac_bits);
        return (word_length + 1) / 2 + frac_bits;
    endfunction

    function automatic int n_iter(input int word_length, input int frac_bits);
        return result_len(word_length, frac_bits);
    endfunction

    // Radicand rounded up to an even bit count so it splits into digit pairs.
    function automatic int pad_width(input int word_length);
        return 2 * ((word_length + 1) / 2);
    endfunction

endpackage

`default_nettype wire

// File: rtl/square_root_seq_step.sv
// ============================================================================
// Module   : sqrt_step
// Purpose  : One combinational restoring square-root digit step.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sqrt_step #(
    parameter int RESULT_LENGTH = 8
) (
    input  logic [RESULT_LENGTH+1:0] rem_i,
    input  logic [RESULT_LENGTH-1:0] root_i,
    input  logic [1:0]               bits_i,
    output logic [RESULT_LENGTH+1:0] rem_o,
    output logic [RESULT_LENGTH-1:0] root_o
);

    logic [RESULT_LENGTH+1:0] w_rem_sh;
    logic [RESULT_LENGTH+1:0] w_trial;
    logic [RESULT_LENGTH+1:0] w_diff;
    logic                     w_ge;

    // The remainder never exceeds 2*root, so the top two bits shifted out are zero.
    assign w_rem_sh = (rem_i << 2) | {{RESULT_LENGTH{1'b0}}, bits_i};
    assign w_trial  = {root_i, 2'b01};
    assign w_ge     = (w_rem_sh >= w_trial);
    assign w_diff   = w_rem_sh - w_trial;

    assign rem_o  = w_ge ? w_diff : w_rem_sh;
    assign root_o = (root_i << 1) | RESULT_LENGTH'(w_ge);

endmodule

`default_nettype wire

// File: rtl/square_root_seq.sv
// ============================================================================
// Module   : square_root_seq
// Purpose  : Multi-cycle restoring integer/fixed-point square root with
//            start/done handshake, abort and held result.
// Revision : 1.0
// ============================================================================
`default_nettype none

module square_root_seq
    import sqrt_pkg::*;
#(
    parameter  int WORD_LENGTH   = 16,
    parameter  int FRAC_BITS     = 0,
    localparam int RESULT_LENGTH = result_len(WORD_LENGTH, FRAC_BITS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic [WORD_LENGTH-1:0]   DataInput,
    output logic                     ready,
    output logic                     busy,
    output logic                     done,
    output logic [RESULT_LENGTH-1:0] result,
    output logic [RESULT_LENGTH:0]   residue
);

    localparam int N_ITER = n_iter(WORD_LENGTH, FRAC_BITS);
    localparam int RAD_W  = pad_width(WORD_LENGTH) + 2 * FRAC_BITS;
    localparam int CNT_W  = $clog2(N_ITER + 1);
    localparam int REM_W  = RESULT_LENGTH + 2;

    state_e                   state_q,   state_d;
    logic [CNT_W-1:0]         cnt_q,     cnt_d;
    logic [RAD_W-1:0]         rad_q,     rad_d;
    logic [REM_W-1:0]         rem_q,     rem_d;
    logic [RESULT_LENGTH-1:0] root_q,    root_d;
    logic [RESULT_LENGTH-1:0] result_q,  result_d;
    logic [RESULT_LENGTH:0]   residue_q, residue_d;
    logic                     ready_q,   ready_d;
    logic                     busy_q,    busy_d;
    logic                     done_q,    done_d;

    logic [REM_W-1:0]         w_rem_nx;
    logic [RESULT_LENGTH-1:0] w_root_nx;
    logic [RAD_W-1:0]         w_rad_load;

    assign w_rad_load = RAD_W'(DataInput) << (2 * FRAC_BITS);

    sqrt_step #(
        .RESULT_LENGTH (RESULT_LENGTH)
    ) u_step (
        .rem_i  (rem_q),
        .root_i (root_q),
        .bits_i (rad_q[RAD_W-1 -: 2]),
        .rem_o  (w_rem_nx),
        .root_o (w_root_nx)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rad_d     = rad_q;
        rem_d     = rem_q;
        root_d    = root_q;
        result_d  = result_q;
        residue_d = residue_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rad_d   = w_rad_load;
                    rem_d   = '0;
                    root_d  = '0;
                    cnt_d   = CNT_W'(N_ITER - 1);
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                // Abort takes priority even on the final step, so no done escapes.
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    rad_d  = rad_q << 2;
                    rem_d  = w_rem_nx;
                    root_d = w_root_nx;
                    if (cnt_q == '0) begin
                        result_d  = w_root_nx;
                        residue_d = w_rem_nx[RESULT_LENGTH:0];
                        state_d   = S_DONE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d == S_BUSY);
        done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rad_q     <= '0;
            rem_q     <= '0;
            root_q    <= '0;
            result_q  <= '0;
            residue_q <= '0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rad_q     <= rad_d;
            rem_q     <= rem_d;
            root_q    <= root_d;
            result_q  <= result_d;
            residue_q <= residue_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign ready   = ready_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign result  = result_q;
    assign residue = residue_q;

endmodule

`default_nettype wire

// File: tb/tb_square_root_seq.sv
// ============================================================================
// Module   : tb_square_root_seq
// Purpose  : Self-checking bench for square_root_seq (three configurations).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_square_root_seq;
    import sqrt_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- config A: 16/0 ----------------
    logic        a_start = 1'b0, a_abort = 1'b0;
    logic [15:0] a_din = '0;
    logic        a_ready, a_busy, a_done;
    logic [7:0]  a_result;
    logic [8:0]  a_residue;

    square_root_seq #(.WORD_LENGTH(16), .FRAC_BITS(0)) u_a (
        .clk(clk), .reset(reset), .start(a_start), .abort(a_abort), .DataInput(a_din),
        .ready(a_ready), .busy(a_busy), .done(a_done), .result(a_result), .residue(a_residue));

    // ---------------- config B: 9/0 ----------------
    logic        b_start = 1'b0, b_abort = 1'b0;
    logic [8:0]  b_din = '0;
    logic        b_ready, b_busy, b_done;
    logic [4:0]  b_result;
    logic [5:0]  b_residue;

    square_root_seq #(.WORD_LENGTH(9), .FRAC_BITS(0)) u_b (
        .clk(clk), .reset(reset), .start(b_start), .abort(b_abort), .DataInput(b_din),
        .ready(b_ready), .busy(b_busy), .done(b_done), .result(b_result), .residue(b_residue));

    // ---------------- config C: 16/4 ----------------
    logic        c_start = 1'b0, c_abort = 1'b0;
    logic [15:0] c_din = '0;
    logic        c_ready, c_busy, c_done;
    logic [11:0] c_result;
    logic [12:0] c_residue;

    square_root_seq #(.WORD_LENGTH(16), .FRAC_BITS(4)) u_c (
        .clk(clk), .reset(reset), .start(c_start), .abort(c_abort), .DataInput(c_din),
        .ready(c_ready), .busy(c_busy), .done(c_done), .result(c_result), .residue(c_residue));

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint isqrt(input longint x);
        longint r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    // Scoreboard for config A
    typedef struct {
        longint res;
        longint rsd;
        int     t0;
    } exp_t;
    exp_t sbq[$];

    always @(negedge clk) begin
        if (!reset && a_done) begin
            if (sbq.size() == 0) begin
                chk("a_unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("a_result",  longint'(a_result),  e.res);
                chk("a_residue", longint'(a_residue), e.rsd);
                chk("a_latency", longint'(cyc - e.t0), 8);
            end
        end
    end

    task automatic a_go(input logic [15:0] din, input logic with_abort);
        int n = 0;
        exp_t e;
        while (!a_ready && n < 40) begin @(negedge clk); n++; end
        if (!a_ready) begin chk("a_ready_timeout", 0, 1); return; end
        a_start = 1'b1;
        a_abort = with_abort;
        a_din   = din;
        e.res = isqrt(longint'(din));
        e.rsd = longint'(din) - e.res * e.res;
        e.t0  = cyc + 1;
        sbq.push_back(e);
        @(negedge clk);
        a_start = 1'b0;
        a_abort = 1'b0;
        a_din   = 16'hxxxx;
    endtask

    task automatic a_drain();
        int n = 0;
        while ((sbq.size() != 0 || !a_ready) && n < 60) begin @(negedge clk); n++; end
        chk("a_drain", longint'(sbq.size()), 0);
    endtask

    typedef struct {
        logic [15:0] din;
        logic [7:0]  res;
        logic [8:0]  rsd;
    } vec_t;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt [10];
        logic [7:0] held_res;
        logic [8:0] held_rsd;
        int lat;

        vt[0] = '{16'd32767, 8'd181, 9'd6};
        vt[1] = '{16'd65535, 8'd255, 9'd510};
        vt[2] = '{16'd0,     8'd0,   9'd0};
        vt[3] = '{16'd1,     8'd1,   9'd0};
        vt[4] = '{16'd2,     8'd1,   9'd1};
        vt[5] = '{16'd3,     8'd1,   9'd2};
        vt[6] = '{16'd4,     8'd2,   9'd0};
        vt[7] = '{16'd65025, 8'd255, 9'd0};
        vt[8] = '{16'd65024, 8'd254, 9'd508};
        vt[9] = '{16'd99,    8'd9,   9'd18};

        repeat (3) @(negedge clk);
        chk("rst_a_ready",   a_ready, 1);
        chk("rst_a_busy",    a_busy, 0);
        chk("rst_a_done",    a_done, 0);
        chk("rst_a_result",  a_result, 0);
        chk("rst_a_residue", a_residue, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_b_ready", b_ready, 1);
        chk("idle_c_ready", c_ready, 1);
        chk("idle_bc_busy", longint'(b_busy | c_busy), 0);

        // Table: direct results, each checked again through the scoreboard
        for (int i = 0; i < 10; i++) begin
            a_go(vt[i].din, 1'b0);
            a_drain();
            chk("tbl_result",  a_result,  vt[i].res);
            chk("tbl_residue", a_residue, vt[i].rsd);
        end

        // Back-to-back 65535 then 0, with a stray start while busy
        a_go(16'd65535, 1'b0);
        chk("b2b_busy", a_busy, 1);
        a_start = 1'b1; a_din = 16'd5;
        @(negedge clk);
        a_start = 1'b0;
        a_go(16'd0, 1'b0);
        a_drain();

        // Abort three cycles into a computation
        held_res = a_result;
        held_rsd = a_residue;
        a_start = 1'b1; a_din = 16'd32767;
        @(negedge clk);
        a_start = 1'b0;
        repeat (2) @(negedge clk);
        a_abort = 1'b1;
        @(negedge clk);
        a_abort = 1'b0;
        chk("abort_ready",   a_ready, 1);
        chk("abort_busy",    a_busy, 0);
        chk("abort_result",  a_result, longint'(held_res));
        chk("abort_residue", a_residue, longint'(held_rsd));
        repeat (12) @(negedge clk);
        a_go(16'd32767, 1'b1);   // start and abort together: start wins
        a_drain();

        // Reset asserted mid-BUSY
        a_start = 1'b1; a_din = 16'd65535;
        @(negedge clk);
        a_start = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_busy_before", a_busy, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_ready",   a_ready, 1);
        chk("mid_rst_busy",    a_busy, 0);
        chk("mid_rst_result",  a_result, 0);
        chk("mid_rst_residue", a_residue, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Config B: odd width
        b_start = 1'b1; b_din = 9'd511;
        @(negedge clk);
        b_start = 1'b0;
        lat = 0;
        while (!b_done && lat < 30) begin @(negedge clk); lat++; end
        chk("b_latency", lat, 5);
        chk("b_result",  b_result, 22);
        chk("b_residue", b_residue, 27);
        @(negedge clk);
        chk("b_done_pulse", b_done, 0);

        // Config C: fractional bits
        for (int k = 0; k < 2; k++) begin
            longint x, r;
            c_din = (k == 0) ? 16'd2 : 16'd65535;
            x = longint'(c_din) * 256;
            r = isqrt(x);
            c_start = 1'b1;
            @(negedge clk);
            c_start = 1'b0;
            lat = 0;
            while (!c_done && lat < 40) begin @(negedge clk); lat++; end
            chk("c_latency", lat, 12);
            chk("c_result",  c_result, r);
            chk("c_residue", c_residue, x - r * r);
            @(negedge clk);
        end
        chk("c_known_result", c_result, 4095);

        // Strided sweep of the 16-bit input space against the model
        for (int v = 0; v < 65536; v += 37) a_go(16'(v), 1'b0);
        for (int v = 65520; v < 65536; v++) a_go(16'(v), 1'b0);
        a_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
